// File: rtl/envelope_pkg.sv
// Shared types and constants for the eight-voice ADSR envelope generator.
package envelope_pkg;

    localparam int unsigned LEVEL_W          = 16;
    localparam int unsigned N_VOICES_DEFAULT = 8;

    typedef enum logic [2:0] {
        ENV_IDLE,
        ENV_ATTACK,
        ENV_DECAY,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_state_t;

    typedef enum logic {
        SEQ_IDLE,
        SEQ_BUSY
    } seq_state_t;

    // Sustain setting occupies the top byte of the level range.
    function automatic logic [LEVEL_W-1:0] sustain_target(input logic [7:0] sustain_level);
        return {sustain_level, {(LEVEL_W-8){1'b0}}};
    endfunction

endpackage

// File: rtl/envelope_step.sv
// Combinational single-voice ADSR update: gate edges first, then the per-state step.
module envelope_step
    import envelope_pkg::*;
(
    input  env_state_t         state,
    input  logic [LEVEL_W-1:0] level,
    input  logic               gate,
    input  logic               prev_gate,
    input  logic [LEVEL_W-1:0] attack_rate,
    input  logic [LEVEL_W-1:0] decay_rate,
    input  logic [7:0]         sustain_level,
    input  logic [LEVEL_W-1:0] release_rate,
    output env_state_t         next_state,
    output logic [LEVEL_W-1:0] next_level
);

    logic               rise;
    logic               fall;
    logic [LEVEL_W-1:0] sus_lvl;
    logic [LEVEL_W:0]   atk_sum;
    logic [LEVEL_W-1:0] atk_level;
    logic [LEVEL_W-1:0] dec_level;
    logic [LEVEL_W-1:0] rel_level;
    env_state_t         atk_state;
    env_state_t         dec_state;
    env_state_t         rel_state;

    always_comb begin
        rise      = gate & ~prev_gate;
        fall      = ~gate & prev_gate;
        sus_lvl   = sustain_target(sustain_level);
        atk_sum   = {1'b0, level} + {1'b0, attack_rate};
        atk_level = atk_sum[LEVEL_W-1:0];
        atk_state = ENV_ATTACK;
        dec_level = level - decay_rate;
        dec_state = ENV_DECAY;
        rel_level = level - release_rate;
        rel_state = ENV_RELEASE;

        if (atk_sum >= {1'b0, {LEVEL_W{1'b1}}}) begin
            atk_level = '1;
            atk_state = ENV_DECAY;
        end
        // Compare against the gap to the target so the subtraction never wraps.
        if ((level <= sus_lvl) || ((level - sus_lvl) <= decay_rate)) begin
            dec_level = sus_lvl;
            dec_state = ENV_SUSTAIN;
        end
        if (release_rate >= level) begin
            rel_level = '0;
            rel_state = ENV_IDLE;
        end
    end

    always_comb begin
        next_state = state;
        next_level = level;
        if (rise) begin
            next_state = atk_state;
            next_level = atk_level;
        end else if (fall && (state == ENV_ATTACK || state == ENV_DECAY || state == ENV_SUSTAIN)) begin
            next_state = rel_state;
            next_level = rel_level;
        end else begin
            case (state)
                ENV_IDLE: begin
                    next_level = '0;
                end
                ENV_ATTACK: begin
                    next_state = atk_state;
                    next_level = atk_level;
                end
                ENV_DECAY: begin
                    next_state = dec_state;
                    next_level = dec_level;
                end
                ENV_SUSTAIN: begin
                    next_level = sus_lvl;
                end
                ENV_RELEASE: begin
                    next_state = rel_state;
                    next_level = rel_level;
                end
                default: begin
                    next_state = ENV_IDLE;
                    next_level = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/envelope_generator.sv
// Eight-voice ADSR envelope generator; one shared step unit walks the voices once per tick.
module envelope_generator
    import envelope_pkg::*;
#(
    parameter int unsigned N_VOICES = N_VOICES_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [N_VOICES-1:0] gate,
    input  logic [15:0]         attack_rate,
    input  logic [15:0]         decay_rate,
    input  logic [7:0]          sustain_level,
    input  logic [15:0]         release_rate,
    output logic [31:0]         voice_volumes [N_VOICES-1:0],
    output logic [N_VOICES-1:0] active,
    output logic                done,
    output logic                overrun
);

    localparam int unsigned     IDX_W    = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);

    env_state_t         voice_state [N_VOICES];
    logic [LEVEL_W-1:0] voice_level [N_VOICES];
    logic [N_VOICES-1:0] prev_gate;

    seq_state_t         seq_state;
    seq_state_t         seq_next;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_next;
    logic               done_next;

    env_state_t         step_state;
    logic [LEVEL_W-1:0] step_level;

    envelope_step u_step (
        .state         (voice_state[idx]),
        .level         (voice_level[idx]),
        .gate          (gate[idx]),
        .prev_gate     (prev_gate[idx]),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .next_state    (step_state),
        .next_level    (step_level)
    );

    always_comb begin
        seq_next  = seq_state;
        idx_next  = idx;
        done_next = 1'b0;
        case (seq_state)
            SEQ_IDLE: begin
                if (tick) begin
                    seq_next = SEQ_BUSY;
                    idx_next = '0;
                end
            end
            SEQ_BUSY: begin
                if (idx == LAST_IDX) begin
                    seq_next  = SEQ_IDLE;
                    done_next = 1'b1;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            default: begin
                seq_next = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_state <= SEQ_IDLE;
            idx       <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            prev_gate <= '0;
            for (int unsigned i = 0; i < N_VOICES; i++) begin
                voice_state[i] <= ENV_IDLE;
                voice_level[i] <= '0;
            end
        end else begin
            seq_state <= seq_next;
            idx       <= idx_next;
            done      <= done_next;
            if (tick && seq_state == SEQ_BUSY) begin
                overrun <= 1'b1;
            end
            if (seq_state == SEQ_BUSY) begin
                voice_state[idx] <= step_state;
                voice_level[idx] <= step_level;
                prev_gate[idx]   <= gate[idx];
            end
        end
    end

    // Outputs come straight from the per-voice registers, so they only move on that voice's update.
    always_comb begin
        active = '0;
        for (int unsigned i = 0; i < N_VOICES; i++) begin
            voice_volumes[i] = {{(32-LEVEL_W){1'b0}}, voice_level[i]};
            active[i]        = (voice_state[i] != ENV_IDLE);
        end
    end

endmodule

// File: tb/tb_envelope_generator.sv
// Directed bench for envelope_generator with a per-voice reference model feeding a scoreboard.
module tb_envelope_generator;

    localparam int M_IDLE = 0;
    localparam int M_ATK  = 1;
    localparam int M_DEC  = 2;
    localparam int M_SUS  = 3;
    localparam int M_REL  = 4;

    typedef struct {
        int          voice;
        logic [31:0] vol;
        logic        act;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [7:0]  gate;
    logic [15:0] attack_rate;
    logic [15:0] decay_rate;
    logic [7:0]  sustain_level;
    logic [15:0] release_rate;
    logic [31:0] voice_volumes [7:0];
    logic [7:0]  active;
    logic        done;
    logic        overrun;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_state [8];
    int   m_level [8];
    bit   m_prev  [8];
    exp_t exp_q [$];

    always #5 clk = ~clk;

    envelope_generator #(.N_VOICES(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .voice_volumes (voice_volumes),
        .active        (active),
        .done          (done),
        .overrun       (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_state[i] = M_IDLE;
            m_level[i] = 0;
            m_prev[i]  = 1'b0;
        end
    endtask

    task automatic model_sweep();
        for (int i = 0; i < 8; i++) begin
            int st;
            int lvl;
            int s;
            bit g;
            bit rise;
            bit fall;
            exp_t e;
            st   = m_state[i];
            lvl  = m_level[i];
            s    = int'(sustain_level) * 256;
            g    = gate[i];
            rise = g && !m_prev[i];
            fall = !g && m_prev[i];
            m_prev[i] = g;
            if (rise) st = M_ATK;
            else if (fall && (st == M_ATK || st == M_DEC || st == M_SUS)) st = M_REL + 10;
            case (st)
                M_IDLE: lvl = 0;
                M_ATK: begin
                    lvl = lvl + int'(attack_rate);
                    if (lvl >= 65535) begin lvl = 65535; st = M_DEC; end
                end
                M_DEC: begin
                    lvl = lvl - int'(decay_rate);
                    if (lvl <= s) begin lvl = s; st = M_SUS; end
                end
                M_SUS: lvl = s;
                default: begin
                    st  = M_REL;
                    lvl = lvl - int'(release_rate);
                    if (lvl <= 0) begin lvl = 0; st = M_IDLE; end
                end
            endcase
            m_state[i] = st;
            m_level[i] = lvl;
            e.voice = i;
            e.vol   = 32'(lvl);
            e.act   = (st != M_IDLE);
            exp_q.push_back(e);
        end
    endtask

    // One tick-driven sweep; extra_at > 0 pulses a second tick that many cycles later.
    task automatic sweep(input int extra_at);
        bit   seen;
        exp_t e;
        tick = 1'b1;
        model_sweep();
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk); #1;
            if (k == 1) tick = 1'b0;
            if (extra_at > 0 && k == extra_at) tick = 1'b1;
            if (extra_at > 0 && k == extra_at + 1) tick = 1'b0;
            if (k >= 2 && k <= 9 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("vol[%0d]", e.voice), voice_volumes[e.voice], e.vol);
                check($sformatf("active[%0d]", e.voice), 32'(active[e.voice]), 32'(e.act));
            end
            if (done) begin
                check("done_latency", 32'(k), 32'd9);
                seen = 1'b1;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        reset = 1'b1; tick = 1'b0; gate = 8'h00;
        attack_rate = 16'h4000; decay_rate = 16'h1000;
        sustain_level = 8'h80; release_rate = 16'h3000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) check($sformatf("reset_vol[%0d]", i), voice_volumes[i], 32'h0);
        check("reset_active", 32'(active), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);

        repeat (3) sweep(0);

        // Voices 0,1,3,5 attack, decay and settle at sustain 8000.
        gate = 8'h2B;
        for (int n = 0; n < 12; n++) begin
            sweep(0);
            if (n == 3) check("v0_peak", voice_volumes[0], 32'h0000FFFF);
        end
        check("v0_sustain", voice_volumes[0], 32'h00008000);

        sustain_level = 8'h40;
        sweep(0);
        check("v1_sustain_track", voice_volumes[1], 32'h00004000);
        sustain_level = 8'h80;
        sweep(0);

        // Release voices 3 and 5; voice 5 re-triggers mid-release.
        gate = 8'h03;
        sweep(0);
        check("v3_rel1", voice_volumes[3], 32'h00005000);
        sweep(0);
        check("v3_rel2", voice_volumes[3], 32'h00002000);
        gate = 8'h23; attack_rate = 16'h1000;
        sweep(0);
        check("v3_rel3", voice_volumes[3], 32'h0);
        check("v3_inactive", 32'(active[3]), 32'h0);
        check("v5_retrigger", voice_volumes[5], 32'h00003000);

        check("overrun_before", 32'(overrun), 32'h0);
        sweep(4);
        check("overrun_set", 32'(overrun), 32'h1);
        sweep(0);
        check("overrun_sticky", 32'(overrun), 32'h1);

        // Reset during cycle T+4: voices 0..2 updated, voice 3 must not be.
        gate = 8'hFF; tick = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) tick = 1'b0;
        end
        check("midsweep_v2", voice_volumes[2], 32'h00001000);
        check("midsweep_v3_untouched", 32'(active[3]), 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) check($sformatf("abort_vol[%0d]", i), voice_volumes[i], 32'h0);
        check("abort_active", 32'(active), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_overrun", 32'(overrun), 32'h0);
        model_reset();

        tick = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; tick = 1'b0; gate = 8'h00;
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("tick_during_reset", 32'(saw_done), 32'h0);

        gate = 8'h01;
        sweep(0);
        check("post_reset_attack", voice_volumes[0], 32'h00001000);
        attack_rate = 16'h0000;
        sweep(0);
        check("zero_rate_hold", voice_volumes[0], 32'h00001000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
